// File: rtl/serial_parallel_aligner_if.sv
// Serial-in / word-out bundle between the line sampler (master) and the comma aligner (slave).
interface serial_parallel_aligner_if #(
  parameter int unsigned WIDTH = 8
);
  logic             DATA_IN;
  logic             BIT_EN;
  logic [WIDTH-1:0] DATA_OUT;
  logic             VALID_OUT;
  logic             IS_COMMA;
  logic             ALIGNED;

  modport master (
    output DATA_IN,
    output BIT_EN,
    input  DATA_OUT,
    input  VALID_OUT,
    input  IS_COMMA,
    input  ALIGNED
  );

  modport slave (
    input  DATA_IN,
    input  BIT_EN,
    output DATA_OUT,
    output VALID_OUT,
    output IS_COMMA,
    output ALIGNED
  );
endinterface

// File: rtl/serial_parallel_aligner.sv
// Serial-to-parallel deserialiser that hunts for a comma at any bit offset, confirms
// word alignment over LOCK_COUNT commas and drops lock after LOSS_COUNT misaligned commas.
module serial_parallel_aligner #(
  parameter int unsigned      WIDTH      = 8,
  parameter logic [WIDTH-1:0] COMMA      = WIDTH'(8'hBC),
  parameter int unsigned      LOCK_COUNT = 2,
  parameter int unsigned      LOSS_COUNT = 4
) (
  input logic                      CLK,
  input logic                      RESET,
  serial_parallel_aligner_if.slave bus
);
  localparam int unsigned     BCW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned     LCW      = $clog2(LOCK_COUNT + 1);
  localparam int unsigned     ECW      = $clog2(LOSS_COUNT + 1);
  localparam logic [BCW-1:0]  BIT_LAST = BCW'(WIDTH - 1);
  localparam logic [LCW-1:0]  LOCK_MAX = LCW'(LOCK_COUNT);
  localparam logic [ECW-1:0]  LOSS_MAX = ECW'(LOSS_COUNT);

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t           state_r,    state_s;
  logic [WIDTH-1:0] sr_r,       sr_s;
  logic [BCW-1:0]   bit_cnt_r,  bit_cnt_s;
  logic [LCW-1:0]   lock_cnt_r, lock_cnt_s;
  logic [ECW-1:0]   err_cnt_r,  err_cnt_s;
  logic [WIDTH-1:0] dout_r,     dout_s;
  logic             valid_r,    valid_s;
  logic             comma_r,    comma_s;
  logic             aligned_r,  aligned_s;

  logic [WIDTH-1:0] shift_s;
  logic             match_s;
  logic             boundary_s;
  logic [LCW-1:0]   lock_inc_s;
  logic [ECW-1:0]   err_inc_s;

  // Counters saturate at their limits instead of wrapping.
  assign shift_s    = {bus.DATA_IN, sr_r[WIDTH-1:1]};
  assign match_s    = (shift_s == COMMA);
  assign boundary_s = (bit_cnt_r == BIT_LAST);
  assign lock_inc_s = (lock_cnt_r == LOCK_MAX) ? LOCK_MAX : lock_cnt_r + LCW'(1);
  assign err_inc_s  = (err_cnt_r == LOSS_MAX) ? LOSS_MAX : err_cnt_r + ECW'(1);

  // Next-state and output decode; with BIT_EN low everything holds and VALID_OUT drops.
  always_comb begin
    state_s    = state_r;
    sr_s       = sr_r;
    bit_cnt_s  = bit_cnt_r;
    lock_cnt_s = lock_cnt_r;
    err_cnt_s  = err_cnt_r;
    dout_s     = dout_r;
    valid_s    = 1'b0;
    comma_s    = comma_r;
    if (bus.BIT_EN) begin
      sr_s      = shift_s;
      bit_cnt_s = boundary_s ? BCW'(0) : bit_cnt_r + BCW'(1);
      case (state_r)
        ST_HUNT: begin
          if (match_s) begin
            bit_cnt_s  = BCW'(0);
            lock_cnt_s = LCW'(1);
            if (LOCK_COUNT == 1) begin
              state_s   = ST_LOCKED;
              err_cnt_s = ECW'(0);
            end else begin
              state_s = ST_SYNC;
            end
          end else begin
            state_s = ST_HUNT;
          end
        end
        ST_SYNC: begin
          if (boundary_s && match_s) begin
            lock_cnt_s = lock_inc_s;
            if (lock_inc_s >= LOCK_MAX) begin
              state_s   = ST_LOCKED;
              err_cnt_s = ECW'(0);
            end else begin
              state_s = ST_SYNC;
            end
          end else if (match_s) begin
            bit_cnt_s  = BCW'(0);
            lock_cnt_s = LCW'(1);
          end else begin
            state_s = ST_SYNC;
          end
        end
        ST_LOCKED: begin
          if (boundary_s) begin
            dout_s  = shift_s;
            valid_s = 1'b1;
            comma_s = match_s;
            if (match_s) begin
              err_cnt_s = ECW'(0);
            end else begin
              err_cnt_s = err_cnt_r;
            end
          end else if (match_s) begin
            // A comma off the word grid: count it, keep the current grid until the limit.
            if (err_inc_s >= LOSS_MAX) begin
              state_s    = ST_SYNC;
              bit_cnt_s  = BCW'(0);
              lock_cnt_s = LCW'(1);
              err_cnt_s  = ECW'(0);
            end else begin
              err_cnt_s = err_inc_s;
            end
          end else begin
            state_s = ST_LOCKED;
          end
        end
        default: begin
          state_s    = ST_HUNT;
          bit_cnt_s  = BCW'(0);
          lock_cnt_s = LCW'(0);
          err_cnt_s  = ECW'(0);
        end
      endcase
    end else begin
      valid_s = 1'b0;
    end
    aligned_s = (state_s == ST_LOCKED);
  end

  // State and output registers.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_r    <= ST_HUNT;
      sr_r       <= {WIDTH{1'b0}};
      bit_cnt_r  <= BCW'(0);
      lock_cnt_r <= LCW'(0);
      err_cnt_r  <= ECW'(0);
      dout_r     <= {WIDTH{1'b0}};
      valid_r    <= 1'b0;
      comma_r    <= 1'b0;
      aligned_r  <= 1'b0;
    end else begin
      state_r    <= state_s;
      sr_r       <= sr_s;
      bit_cnt_r  <= bit_cnt_s;
      lock_cnt_r <= lock_cnt_s;
      err_cnt_r  <= err_cnt_s;
      dout_r     <= dout_s;
      valid_r    <= valid_s;
      comma_r    <= comma_s;
      aligned_r  <= aligned_s;
    end
  end

  assign bus.DATA_OUT  = dout_r;
  assign bus.VALID_OUT = valid_r;
  assign bus.IS_COMMA  = comma_r;
  assign bus.ALIGNED   = aligned_r;
endmodule

// File: tb/tb_serial_parallel_aligner.sv
// Directed bench for serial_parallel_aligner: an 8-bit/LOCK_COUNT=2 instance and a
// 10-bit/LOCK_COUNT=1 instance, expected words queued as stimulus is sent.
module tb_serial_parallel_aligner;
  logic CLK = 1'b0;
  logic RESET;
  int   n_cmp  = 0;
  int   n_fail = 0;
  logic [10:0] qa[$];
  logic [10:0] qb[$];

  serial_parallel_aligner_if #(.WIDTH(8))  bus_a ();
  serial_parallel_aligner_if #(.WIDTH(10)) bus_b ();

  serial_parallel_aligner #(
    .WIDTH(8), .COMMA(8'hBC), .LOCK_COUNT(2), .LOSS_COUNT(4)
  ) dut_a (
    .CLK(CLK), .RESET(RESET), .bus(bus_a)
  );

  serial_parallel_aligner #(
    .WIDTH(10), .COMMA(10'h17C), .LOCK_COUNT(1), .LOSS_COUNT(4)
  ) dut_b (
    .CLK(CLK), .RESET(RESET), .bus(bus_b)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_out(input bit sel, input logic en);
    logic [10:0] e;
    logic [9:0]  d;
    logic        v, al, ic;
    int          n;
    string       p;
    if (sel) begin
      p = "B"; v = bus_b.VALID_OUT; al = bus_b.ALIGNED; ic = bus_b.IS_COMMA;
      d = bus_b.DATA_OUT; n = qb.size();
    end else begin
      p = "A"; v = bus_a.VALID_OUT; al = bus_a.ALIGNED; ic = bus_a.IS_COMMA;
      d = {2'b00, bus_a.DATA_OUT}; n = qa.size();
    end
    if (!en) chk({p, "_valid_idle"}, 32'(v), 32'd0);
    if (v === 1'b1) begin
      chk({p, "_valid_only_aligned"}, 32'(al), 32'd1);
      chk({p, "_valid_expected"}, 32'(n != 0), 32'd1);
      if (n != 0) begin
        if (sel) e = qb.pop_front();
        else     e = qa.pop_front();
        chk({p, "_data_out"}, 32'(d), 32'(e[9:0]));
        chk({p, "_is_comma"}, 32'(ic), 32'(e[10]));
      end
    end
  endtask

  task automatic drive(input bit sel, input logic b, input logic en);
    @(negedge CLK);
    if (sel) begin
      bus_b.DATA_IN = b; bus_b.BIT_EN = en; bus_a.BIT_EN = 1'b0;
    end else begin
      bus_a.DATA_IN = b; bus_a.BIT_EN = en; bus_b.BIT_EN = 1'b0;
    end
    @(posedge CLK);
    #1;
    check_out(sel, en);
  endtask

  task automatic send_a(input logic [7:0] bits, input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps) repeat ($urandom_range(5, 1)) drive(1'b0, 1'($urandom_range(1, 0)), 1'b0);
      drive(1'b0, bits[i], 1'b1);
    end
  endtask

  task automatic send_b(input logic [9:0] bits, input int n);
    for (int i = 0; i < n; i++) drive(1'b1, bits[i], 1'b1);
  endtask

  // Three filler bits then n commas, each ending 3 bits past the word grid.
  task automatic shifted_block(input int n);
    qa.push_back({3'b000, 8'hE0});
    for (int k = 1; k < n; k++) qa.push_back({3'b000, 8'hE5});
    send_a(8'h00, 3, 1'b0);
    for (int k = 1; k <= n; k++) begin
      send_a(8'hBC, 8, 1'b0);
      chk("A_aligned_shifted", 32'(bus_a.ALIGNED), (k == 4) ? 32'd0 : 32'd1);
    end
    chk("A_queue_drained_shifted", 32'(qa.size()), 32'd0);
  endtask

  initial begin
    bus_a.DATA_IN = 1'b0; bus_a.BIT_EN = 1'b0;
    bus_b.DATA_IN = 1'b0; bus_b.BIT_EN = 1'b0;
    RESET = 1'b1;
    #2 RESET = 1'b0;
    #10;
    chk("A_reset_data",    32'(bus_a.DATA_OUT),  32'd0);
    chk("A_reset_valid",   32'(bus_a.VALID_OUT), 32'd0);
    chk("A_reset_comma",   32'(bus_a.IS_COMMA),  32'd0);
    chk("A_reset_aligned", 32'(bus_a.ALIGNED),   32'd0);
    chk("B_reset_data",    32'(bus_b.DATA_OUT),  32'd0);
    chk("B_reset_aligned", 32'(bus_b.ALIGNED),   32'd0);
    @(negedge CLK);
    RESET = 1'b1;

    // Junk bits then two commas to lock, then a data word.
    send_a(8'h05, 3, 1'b0);
    send_a(8'hBC, 8, 1'b0);
    chk("A_aligned_after_1st_comma", 32'(bus_a.ALIGNED), 32'd0);
    send_a(8'hBC, 8, 1'b0);
    chk("A_aligned_after_2nd_comma", 32'(bus_a.ALIGNED), 32'd1);
    qa.push_back({3'b000, 8'h5A});
    send_a(8'h5A, 8, 1'b0);
    chk("A_queue_drained_t1", 32'(qa.size()), 32'd0);

    // Locked word stream with comma qualification.
    qa.push_back({3'b100, 8'hBC});
    qa.push_back({3'b000, 8'hA3});
    qa.push_back({3'b100, 8'hBC});
    send_a(8'hBC, 8, 1'b0);
    send_a(8'hA3, 8, 1'b0);
    send_a(8'hBC, 8, 1'b0);
    chk("A_queue_drained_t2", 32'(qa.size()), 32'd0);
    chk("A_aligned_t2", 32'(bus_a.ALIGNED), 32'd1);

    // Four misaligned commas drop lock; one aligned comma re-locks.
    shifted_block(4);
    send_a(8'hBC, 8, 1'b0);
    chk("A_relock", 32'(bus_a.ALIGNED), 32'd1);
    // Three misaligned then an aligned comma, twice: the aligned one must clear the count.
    for (int r = 0; r < 2; r++) begin
      shifted_block(3);
      qa.push_back({3'b000, 8'h05});
      send_a(8'h00, 5, 1'b0);
      qa.push_back({3'b100, 8'hBC});
      send_a(8'hBC, 8, 1'b0);
      chk("A_aligned_after_reset_err", 32'(bus_a.ALIGNED), 32'd1);
      chk("A_queue_drained_t3", 32'(qa.size()), 32'd0);
    end

    // Same stream as the first scenario with idle gaps between bits.
    @(negedge CLK); RESET = 1'b0;
    @(negedge CLK); RESET = 1'b1;
    send_a(8'h05, 3, 1'b1);
    send_a(8'hBC, 8, 1'b1);
    send_a(8'hBC, 8, 1'b1);
    chk("A_aligned_gaps", 32'(bus_a.ALIGNED), 32'd1);
    qa.push_back({3'b000, 8'h5A});
    send_a(8'h5A, 8, 1'b1);
    chk("A_queue_drained_t4", 32'(qa.size()), 32'd0);
    chk("A_data_held_t4", 32'(bus_a.DATA_OUT), 32'h5A);

    // Asynchronous reset mid-word while locked.
    send_a(8'hA3, 4, 1'b0);
    @(negedge CLK);
    #2 RESET = 1'b0;
    #1;
    chk("A_async_data",    32'(bus_a.DATA_OUT),  32'd0);
    chk("A_async_valid",   32'(bus_a.VALID_OUT), 32'd0);
    chk("A_async_comma",   32'(bus_a.IS_COMMA),  32'd0);
    chk("A_async_aligned", 32'(bus_a.ALIGNED),   32'd0);
    @(negedge CLK); RESET = 1'b1;
    send_a(8'hA3, 8, 1'b0);
    chk("A_hunt_after_reset", 32'(bus_a.ALIGNED), 32'd0);
    send_a(8'hBC, 8, 1'b0);
    chk("A_sync_after_reset", 32'(bus_a.ALIGNED), 32'd0);
    chk("A_data_zero_hunt",   32'(bus_a.DATA_OUT), 32'd0);
    send_a(8'hBC, 8, 1'b0);
    chk("A_locked_after_reset", 32'(bus_a.ALIGNED), 32'd1);
    qa.push_back({3'b000, 8'h5A});
    send_a(8'h5A, 8, 1'b0);
    chk("A_queue_drained_t5", 32'(qa.size()), 32'd0);

    // 10-bit instance locks on a single comma.
    send_b(10'h003, 2);
    send_b(10'h17C, 10);
    chk("B_aligned_one_comma", 32'(bus_b.ALIGNED), 32'd1);
    qb.push_back({1'b0, 10'h2A5});
    qb.push_back({1'b1, 10'h17C});
    send_b(10'h2A5, 10);
    send_b(10'h17C, 10);
    chk("B_queue_drained", 32'(qb.size()), 32'd0);
    chk("B_aligned_end",   32'(bus_b.ALIGNED), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
